// File: rtl/product_sign_encoder_pkg.sv
// Shared types and helpers for the butterfly complex multiplier back end.
// Product magnitudes are 2n bits; signed intermediates are 2n+1 bits.
package product_sign_encoder_pkg;

  localparam int N_DEFAULT = 8;

  typedef logic signed [2*N_DEFAULT:0] wide_t;

  typedef struct packed {
    wide_t re;
    wide_t im;
  } cplx_t;

  // A zero magnitude negates to zero, so a set flag on 0 is harmless.
  function automatic wide_t resign(input logic [2*N_DEFAULT-1:0] mag, input logic neg);
    wide_t w_m;
    w_m = $signed({1'b0, mag});
    return neg ? -w_m : w_m;
  endfunction

endpackage

// File: rtl/product_sign_encoder_if.sv
// Input/output handshake bundle of the product sign encoder.
// The slave modport is the encoder's view; master is the driver/consumer view.
interface product_sign_encoder_if
  import product_sign_encoder_pkg::*;
#(
  parameter int n = N_DEFAULT
);
  logic                in_valid;
  logic                in_ready;
  logic [2*n-1:0]      MUL1;
  logic [2*n-1:0]      MUL2;
  logic [2*n-1:0]      MUL3;
  logic [2*n-1:0]      MUL4;
  logic                nMUL1;
  logic                nMUL2;
  logic                nMUL3;
  logic                nMUL4;
  logic                out_valid;
  logic                out_ready;
  logic signed [n-1:0] RE;
  logic signed [n-1:0] IM;
  logic                sat;

  modport master (
    output in_valid, MUL1, MUL2, MUL3, MUL4, nMUL1, nMUL2, nMUL3, nMUL4, out_ready,
    input  in_ready, out_valid, RE, IM, sat
  );

  modport slave (
    input  in_valid, MUL1, MUL2, MUL3, MUL4, nMUL1, nMUL2, nMUL3, nMUL4, out_ready,
    output in_ready, out_valid, RE, IM, sat
  );
endinterface

// File: rtl/product_sign_encoder_round_sat.sv
// Rounds a 2n+1 bit product sum back to signed Q1.(n-1), half toward +inf,
// and clamps to the n-bit range. Purely combinational.
module product_sign_encoder_round_sat
  import product_sign_encoder_pkg::*;
#(
  parameter int n     = N_DEFAULT,
  parameter int SHIFT = n - 1
) (
  input  wide_t               i_x,
  output logic signed [n-1:0] o_y,
  output logic                o_clamp
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int WI = $bits(wide_t) + 1;
  localparam logic signed [WI-1:0] HALF = WI'(2 ** (SHIFT - 1));
  localparam logic signed [WI-1:0] MAXV = WI'(2 ** (n - 1) - 1);
  localparam logic signed [WI-1:0] MINV = WI'(-(2 ** (n - 1)));

  logic signed [WI-1:0] w_sum;
  logic signed [WI-1:0] w_t;

  assign w_sum = {i_x[$bits(wide_t)-1], i_x} + HALF;
  assign w_t   = w_sum >>> SHIFT;

  always_comb begin
    o_y     = w_t[n-1:0];
    o_clamp = 1'b0;
    if (w_t > MAXV) begin
      o_y     = MAXV[n-1:0];
      o_clamp = 1'b1;
    end else if (w_t < MINV) begin
      o_y     = MINV[n-1:0];
      o_clamp = 1'b1;
    end
  end

endmodule

// File: rtl/product_sign_encoder.sv
// Restores product signs, forms Re/Im of the complex product, then rounds and
// saturates to n bits. Three register stages with a combinational ready chain.
module product_sign_encoder
  import product_sign_encoder_pkg::*;
#(
  parameter int n     = N_DEFAULT,
  parameter int SHIFT = n - 1
) (
  input logic                   clock,
  input logic                   nReset,
  product_sign_encoder_if.slave bus
);
  logic w_ready1, w_ready2, w_ready3;
  logic r_v1, r_v2, r_v3;

  wide_t r_s1, r_s2, r_s3, r_s4;
  cplx_t r_f;

  logic signed [n-1:0] w_re, w_im;
  logic                w_clamp_re, w_clamp_im;
  logic signed [n-1:0] r_re, r_im;
  logic                r_sat;

  // A stage can take new data if it is empty or its contents move on this cycle.
  assign w_ready3 = !r_v3 || bus.out_ready;
  assign w_ready2 = !r_v2 || w_ready3;
  assign w_ready1 = !r_v1 || w_ready2;

  assign bus.in_ready = w_ready1;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_s4 <= '0;
    end else if (w_ready1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1 <= resign(bus.MUL1, bus.nMUL1);
        r_s2 <= resign(bus.MUL2, bus.nMUL2);
        r_s3 <= resign(bus.MUL3, bus.nMUL3);
        r_s4 <= resign(bus.MUL4, bus.nMUL4);
      end
    end
  end

  // Q1 operands keep each product within 2^(2n-2), so the combine cannot overflow.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_v2 <= 1'b0;
      r_f  <= '0;
    end else if (w_ready2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_f.re <= r_s1 - r_s2;
        r_f.im <= r_s3 + r_s4;
      end
    end
  end

  product_sign_encoder_round_sat #(.n(n), .SHIFT(SHIFT)) u_round_re (
    .i_x     (r_f.re),
    .o_y     (w_re),
    .o_clamp (w_clamp_re)
  );

  product_sign_encoder_round_sat #(.n(n), .SHIFT(SHIFT)) u_round_im (
    .i_x     (r_f.im),
    .o_y     (w_im),
    .o_clamp (w_clamp_im)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_v3  <= 1'b0;
      r_re  <= '0;
      r_im  <= '0;
      r_sat <= 1'b0;
    end else if (w_ready3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_re  <= w_re;
        r_im  <= w_im;
        r_sat <= w_clamp_re || w_clamp_im;
      end
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.RE        = r_re;
  assign bus.IM        = r_im;
  assign bus.sat       = r_sat;

endmodule

// File: tb/tb_product_sign_encoder.sv
// Directed and randomised checks of product_sign_encoder (n=8, SHIFT=7) using
// immediate assertions and an integer reference model of the complex product.
module tb_product_sign_encoder;
  import product_sign_encoder_pkg::*;

  localparam int N = 8;

  logic clock  = 1'b0;
  logic nReset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  product_sign_encoder_if #(.n(N)) bus ();

  product_sign_encoder #(.n(N), .SHIFT(N-1)) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_word(input int m1, input int m2, input int m3, input int m4, input logic [3:0] f);
    bus.MUL1  = 16'(m1);
    bus.MUL2  = 16'(m2);
    bus.MUL3  = 16'(m3);
    bus.MUL4  = 16'(m4);
    bus.nMUL1 = f[0];
    bus.nMUL2 = f[1];
    bus.nMUL3 = f[2];
    bus.nMUL4 = f[3];
  endtask

  // Round half up via floor division, then clamp to the 8-bit signed range.
  function automatic int rnd_sat(input int x, output logic s);
    int y;
    int t;
    y = x + 64;
    if (y >= 0) t = y / 128;
    else        t = -((-y + 127) / 128);
    s = 1'b0;
    if (t > 127) begin
      t = 127;
      s = 1'b1;
    end else if (t < -128) begin
      t = -128;
      s = 1'b1;
    end
    return t;
  endfunction

  function automatic logic [16:0] model(input int m1, input int m2, input int m3, input int m4,
                                        input logic [3:0] f);
    int   s1, s2, s3, s4, re, im;
    logic sr, si;
    s1 = f[0] ? -m1 : m1;
    s2 = f[1] ? -m2 : m2;
    s3 = f[2] ? -m3 : m3;
    s4 = f[3] ? -m4 : m4;
    re = rnd_sat(s1 - s2, sr);
    im = rnd_sat(s3 + s4, si);
    return {re[7:0], im[7:0], sr | si};
  endfunction

  task automatic send_one(input string tag, input int m1, input int m2, input int m3, input int m4,
                          input logic [3:0] f, input int e_re, input int e_im, input int e_sat);
    int lat;
    drive_word(m1, m2, m3, m4, f);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_re"}, $signed(bus.RE), e_re);
    check({tag, "_im"}, $signed(bus.IM), e_im);
    check({tag, "_sat"}, {31'd0, bus.sat}, e_sat);
    tick();
  endtask

  // Lockstep driver/scoreboard. Mode 0: deterministic words with out_ready low on
  // cycles 4..6. Mode 1: random words, random in_valid and out_ready.
  task automatic run_stream(input string tag, input int n_words, input bit rnd_mode);
    logic [16:0] exp_q[$];
    logic [16:0] want;
    logic [17:0] held;
    int          m[4];
    logic [3:0]  f;
    int          sent, got, cyc, budget;
    bit          have, stalled;
    sent = 0; got = 0; cyc = 0; have = 0; stalled = 0; held = '0;
    budget = n_words * 10 + 100;
    while (got < n_words && cyc < budget) begin
      if (!have && sent < n_words) begin
        if (rnd_mode) begin
          for (int k = 0; k < 4; k++)
            m[k] = ($urandom_range(0, 7) == 0) ? 16384 : int'($urandom_range(0, 16384));
          f = 4'($urandom_range(0, 15));
        end else begin
          m[0] = 512 * (sent + 1);
          m[1] = 128 * sent;
          m[2] = 256 * (sent + 1);
          m[3] = 64 * sent;
          f    = 4'(sent);
        end
        drive_word(m[0], m[1], m[2], m[3], f);
        have = 1;
      end
      if (rnd_mode) begin
        bus.in_valid  = have && ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.in_valid  = have;
        bus.out_ready = !(cyc >= 4 && cyc <= 6);
      end
      #1;
      if (stalled)
        check({tag, "_hold"}, {14'd0, bus.out_valid, bus.RE, bus.IM, bus.sat}, {14'd0, held});
      if (!rnd_mode && cyc >= 4 && cyc <= 6)
        check({tag, "_in_ready_low"}, {31'd0, bus.in_ready}, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_word"}, got, -1);
        end else begin
          want = exp_q.pop_front();
          check({tag, "_word"}, {15'd0, bus.RE, bus.IM, bus.sat}, {15'd0, want});
        end
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = {bus.out_valid, bus.RE, bus.IM, bus.sat};
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(m[0], m[1], m[2], m[3], f));
        sent++;
        have = 0;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, "_words_out"}, got, n_words);
    check({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_word(0, 0, 0, 0, 4'b0000);

    // Reset state
    nReset = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_re", $signed(bus.RE), 0);
    check("rst_im", $signed(bus.IM), 0);
    check("rst_sat", {31'd0, bus.sat}, 0);
    nReset = 1'b1;
    tick();
    check("idle_in_ready", {31'd0, bus.in_ready}, 1);

    // Basic scaling and saturation boundaries
    send_one("t1_scale", 4096, 0, 0, 0, 4'b0000, 32, 0, 0);
    send_one("t2_pos_sat", 16384, 16384, 0, 0, 4'b0010, 127, 0, 1);
    send_one("t2_neg_sat", 16384, 16384, 0, 0, 4'b0001, -128, 0, 1);
    send_one("t2_im_sat", 0, 0, 16384, 16384, 4'b1100, 0, -128, 1);

    // Rounding half toward +inf, and negated zero
    send_one("t3_round_up", 0, 0, 64, 0, 4'b0000, 0, 1, 0);
    send_one("t3_round_half_neg", 0, 0, 64, 0, 4'b0100, 0, 0, 0);
    send_one("t3_round_neg", 0, 0, 192, 0, 4'b0100, 0, -1, 0);
    send_one("t3_neg_zero", 0, 0, 0, 0, 4'b1111, 0, 0, 0);
    send_one("t3_mixed", 8192, 4096, 2048, 1024, 4'b1010, 96, 8, 0);

    // Back-to-back stream with a downstream stall
    run_stream("t4_stall", 8, 1'b0);

    // Reset with a full pipe
    bus.out_ready = 1'b0;
    drive_word(4096, 0, 4096, 0, 4'b0000);
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    check("t5_full_valid", {31'd0, bus.out_valid}, 1);
    check("t5_full_re", $signed(bus.RE), 32);
    #2 nReset = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, bus.out_valid}, 0);
    check("t5_rst_re", $signed(bus.RE), 0);
    check("t5_rst_im", $signed(bus.IM), 0);
    tick();
    nReset = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t5_no_output", {31'd0, bus.out_valid}, 0);
    end
    send_one("t5_recover", 0, 4096, 0, 8192, 4'b0000, -32, 64, 0);

    // Random words against the reference model
    run_stream("t6_random", 10000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
